// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths common to master and slave, response codes
// and the slave FSM state encoding.
package apb_pkg;

    localparam int APB_ADDR_WIDTH = 9;
    localparam int APB_DATA_WIDTH = 8;

    localparam logic RESP_OKAY   = 1'b0;
    localparam logic RESP_SLVERR = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between one master and one slave.
interface apb_slave_mem_if
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = APB_DATA_WIDTH
);

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_slave_regfile.sv
// DEPTH x DATA_WIDTH storage: synchronous write, asynchronous read, no reset.
module apb_slave_regfile #(
    parameter int DEPTH      = 256,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_W      = 8
) (
    input  logic                  pclk,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge pclk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave with a fixed number of wait states in front of a register file;
// out-of-range addresses and access phases without a setup return PSLVERR.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH  = APB_DATA_WIDTH,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic           pclk,
    input  logic           preset,
    apb_slave_mem_if.slave bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_WAIT = 2'(WAIT);
    localparam logic [1:0] S_RESP = 2'(RESP);

    localparam logic [3:0] CNT_INIT = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic                  enterResp;
    logic                  memWe;
    logic [DATA_WIDTH-1:0] memRdata;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        err_d     = err_q;
        enterResp = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.psel && !bus.penable) begin
                    addr_d  = bus.paddr;
                    wdata_d = bus.pwdata;
                    write_d = bus.pwrite;
                    err_d   = (32'(bus.paddr) >= DEPTH);
                    if (WAIT_STATES == 0) begin
                        state_d   = S_RESP;
                        enterResp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else if (bus.psel && bus.penable) begin
                    // Access phase without setup: error out, latch nothing.
                    err_d     = 1'b1;
                    state_d   = S_RESP;
                    enterResp = 1'b1;
                end
            end
            S_WAIT: begin
                if (!bus.psel) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d   = S_RESP;
                    enterResp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Read data is looked up with the next-state fields so a zero-wait
        // read can respond straight from the setup edge.
        pready_d  = enterResp;
        pslverr_d = (enterResp && err_d) ? RESP_SLVERR : RESP_OKAY;
        prdata_d  = (enterResp && !write_d && !err_d) ? memRdata : '0;
    end

    assign memWe = (state_q == S_RESP) && write_q && !err_q && !preset;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            err_q     <= err_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    apb_slave_regfile #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .pclk    (pclk),
        .we_i    (memWe),
        .waddr_i (addr_q[IDX_W-1:0]),
        .wdata_i (wdata_q),
        .raddr_i (addr_d[IDX_W-1:0]),
        .rdata_o (memRdata)
    );

    assign bus.prdata  = prdata_q;
    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench for apb_slave_mem: one instance with two wait states and
// one with none, each checked against a word-array model of the memory.
module tb_apb_slave_mem;
    import apb_pkg::*;

    localparam int AW    = 9;
    localparam int DW    = 8;
    localparam int DEPTH = 256;

    logic pclk = 1'b0;
    logic rst2;
    logic rst0;

    int assertCount = 0;
    int failCount   = 0;

    // Index 0: WAIT_STATES=2 instance, index 1: WAIT_STATES=0 instance.
    logic [DW-1:0] model [2][DEPTH];

    apb_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();
    apb_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();

    apb_slave_mem #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(2)
    ) dut2 (
        .pclk   (pclk),
        .preset (rst2),
        .bus    (bus2.slave)
    );

    apb_slave_mem #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(0)
    ) dut0 (
        .pclk   (pclk),
        .preset (rst0),
        .bus    (bus0.slave)
    );

    always #5 pclk = ~pclk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    task automatic setBus(input bit z, input logic sel, input logic en, input logic wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (z) begin
            bus0.psel = sel; bus0.penable = en; bus0.pwrite = wr;
            bus0.paddr = a;  bus0.pwdata = d;
        end else begin
            bus2.psel = sel; bus2.penable = en; bus2.pwrite = wr;
            bus2.paddr = a;  bus2.pwdata = d;
        end
    endtask

    task automatic getOut(input bit z, output logic rdy, output logic err,
                          output logic [DW-1:0] dat);
        if (z) begin
            rdy = bus0.pready; err = bus0.pslverr; dat = bus0.prdata;
        end else begin
            rdy = bus2.pready; err = bus2.pslverr; dat = bus2.prdata;
        end
    endtask

    task automatic setReset(input bit z, input logic v);
        if (z) rst0 = v;
        else   rst2 = v;
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Full APB transfer; called #1 after an edge, returns #1 after the edge
    // that opens the cycle following RESP, with the bus left idle.
    task automatic applyStimulus(input bit z, input logic wr, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input string tag);
        int            ws = z ? 0 : 2;
        logic          expErr;
        logic [DW-1:0] expData;
        logic          rdy, err;
        logic [DW-1:0] dat;
        expErr  = (int'(a) >= DEPTH);
        expData = (!wr && !expErr) ? model[z][a[7:0]] : 8'h00;
        setBus(z, 1'b1, 1'b0, wr, a, d);
        tick();
        // Address and data are scrambled after setup; the slave must ignore them.
        setBus(z, 1'b1, 1'b1, wr, AW'($urandom), DW'($urandom));
        for (int k = 1; k <= ws + 1; k++) begin
            getOut(z, rdy, err, dat);
            checkOutput({tag, " pready"}, 32'(rdy), 32'(k == ws + 1));
            if (k == ws + 1) begin
                checkOutput({tag, " pslverr"}, 32'(err), 32'(expErr));
                checkOutput({tag, " prdata"}, 32'(dat), 32'(expData));
            end
            tick();
        end
        if (wr && !expErr) model[z][a[7:0]] = d;
        getOut(z, rdy, err, dat);
        checkOutput({tag, " pready after resp"}, 32'(rdy), 32'd0);
        setBus(z, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic protocolViolation(input bit z, input string tag);
        logic          rdy, err;
        logic [DW-1:0] dat;
        setBus(z, 1'b1, 1'b1, 1'b1, 9'h005, 8'hFF);
        tick();
        getOut(z, rdy, err, dat);
        checkOutput({tag, " pready"}, 32'(rdy), 32'd1);
        checkOutput({tag, " pslverr"}, 32'(err), 32'd1);
        checkOutput({tag, " prdata"}, 32'(dat), 32'd0);
        setBus(z, 1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        getOut(z, rdy, err, dat);
        checkOutput({tag, " pready cleared"}, 32'(rdy), 32'd0);
    endtask

    // Raises reset in access cycle 'cyc' of a write; the write must not land.
    task automatic resetDuring(input bit z, input int cyc, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input string tag);
        logic          rdy, err;
        logic [DW-1:0] dat;
        setBus(z, 1'b1, 1'b0, 1'b1, a, d);
        tick();
        setBus(z, 1'b1, 1'b1, 1'b1, a, d);
        for (int k = 1; k < cyc; k++) tick();
        setReset(z, 1'b1);
        tick();
        getOut(z, rdy, err, dat);
        checkOutput({tag, " pready"}, 32'(rdy), 32'd0);
        checkOutput({tag, " pslverr"}, 32'(err), 32'd0);
        checkOutput({tag, " prdata"}, 32'(dat), 32'd0);
        setReset(z, 1'b0);
        setBus(z, 1'b0, 1'b0, 1'b0, '0, '0);
        tick();
    endtask

    initial begin
        logic          rdy, err;
        logic [DW-1:0] dat;
        int            gap;
        logic          wr;
        logic [AW-1:0] a;

        rst2 = 1'b1;
        rst0 = 1'b1;
        setBus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        setBus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        tick();
        for (int z = 0; z < 2; z++) begin
            getOut(z[0], rdy, err, dat);
            checkOutput("reset pready", 32'(rdy), 32'd0);
            checkOutput("reset pslverr", 32'(err), 32'd0);
            checkOutput("reset prdata", 32'(dat), 32'd0);
        end
        rst2 = 1'b0;
        rst0 = 1'b0;

        for (int z = 0; z < 2; z++)
            for (int i = 0; i < DEPTH; i++)
                applyStimulus(z[0], 1'b1, AW'(i), DW'($urandom), "preload");

        $display("[TB] directed tests, two wait states");
        applyStimulus(1'b0, 1'b1, 9'h005, 8'hA5, "wr 05");
        applyStimulus(1'b0, 1'b0, 9'h005, 8'h00, "rd 05");
        checkOutput("model 05", 32'(model[0][5]), 32'h0A5);
        applyStimulus(1'b0, 1'b0, 9'h100, 8'h00, "rd 100");
        applyStimulus(1'b0, 1'b1, 9'h1FF, 8'h3C, "wr 1FF");
        applyStimulus(1'b0, 1'b0, 9'h0FF, 8'h00, "rd FF");
        protocolViolation(1'b0, "violation ws2");
        applyStimulus(1'b0, 1'b0, 9'h005, 8'h00, "rd 05 after violation");

        setBus(1'b0, 1'b1, 1'b0, 1'b1, 9'h020, 8'h77);
        tick();
        setBus(1'b0, 1'b1, 1'b1, 1'b1, 9'h020, 8'h77);
        getOut(1'b0, rdy, err, dat);
        checkOutput("abort pready wait", 32'(rdy), 32'd0);
        setBus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        for (int k = 0; k < 4; k++) begin
            tick();
            getOut(1'b0, rdy, err, dat);
            checkOutput("abort pready", 32'(rdy), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 9'h020, 8'h00, "rd 20 after abort");

        resetDuring(1'b0, 1, 9'h010, 8'h99, "reset mid wait");
        applyStimulus(1'b0, 1'b0, 9'h010, 8'h00, "rd 10 after reset");
        resetDuring(1'b0, 3, 9'h011, 8'h5A, "reset at resp");
        applyStimulus(1'b0, 1'b0, 9'h011, 8'h00, "rd 11 after reset");

        $display("[TB] directed tests, zero wait states");
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 1'b1, AW'(i), DW'(8'h11 * (i + 1)), "b2b wr");
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 1'b0, AW'(i), 8'h00, "b2b rd");
        checkOutput("model 03", 32'(model[1][3]), 32'h044);
        applyStimulus(1'b1, 1'b0, 9'h1A0, 8'h00, "ws0 rd oor");
        protocolViolation(1'b1, "violation ws0");
        resetDuring(1'b1, 1, 9'h002, 8'hEE, "ws0 reset at resp");
        applyStimulus(1'b1, 1'b0, 9'h002, 8'h00, "ws0 rd 02 after reset");

        $display("[TB] random traffic");
        for (int z = 0; z < 2; z++) begin
            for (int n = 0; n < 80; n++) begin
                wr = 1'($urandom);
                a  = ($urandom_range(0, 3) == 0) ? AW'(256 + $urandom_range(0, 255))
                                                 : AW'($urandom_range(0, 255));
                applyStimulus(z[0], wr, a, DW'($urandom), "random");
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
